// File: rtl/stage_memory.sv
// Memory stage: runs EX/MEM loads/stores on the data memory over req/ack and loads the MEM/WB register.
// Latency: 1 cycle with no access; an access acked in cycle k updates MEM/WB k+2 edges after it starts.
// Backpressure: mem_stall_req holds upstream while an access is outstanding; a watchdog ends unacked accesses.
module stage_memory #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_clear,
  input  logic [31:0] mem_instr,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic        mem_mem_read,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall_req,
  output logic        dmem_timeout,
  output logic [31:0] wb_instr,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm_ext,
  output logic [4:0]  wb_rd
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          hold_we_q, hold_we_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [31:0]   hold_wdata_q, hold_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout_q, timeout_d;

  logic [31:0]   wb_instr_q, wb_instr_d;
  logic          wb_reg_write_q, wb_reg_write_d;
  logic [1:0]    wb_result_src_q, wb_result_src_d;
  logic [31:0]   wb_alu_result_q, wb_alu_result_d;
  logic [31:0]   wb_read_data_q, wb_read_data_d;
  logic [31:0]   wb_pc_plus_4_q, wb_pc_plus_4_d;
  logic [31:0]   wb_imm_ext_q, wb_imm_ext_d;
  logic [4:0]    wb_rd_q, wb_rd_d;

  logic          access;
  logic          req_raw;
  logic          stall_raw;
  logic [31:0]   load_rdata;

  assign access  = mem_mem_read | mem_mem_write;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Access sequencing: request/stall decode, hold registers, watchdog and read-data capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata_d      = rdata_q;
    timeout_d    = timeout_q;
    req_raw      = 1'b0;
    stall_raw    = 1'b0;
    load_rdata   = 32'h0;
    dmem_we      = hold_we_q;
    dmem_addr    = hold_addr_q;
    dmem_wdata   = hold_wdata_q;
    case (state_q)
      S_IDLE: begin
        dmem_we    = mem_mem_write;
        dmem_addr  = {mem_alu_result[31:2], 2'b00};
        dmem_wdata = mem_write_data;
        if (access) begin
          req_raw      = 1'b1;
          stall_raw    = 1'b1;
          hold_we_d    = mem_mem_write;
          hold_addr_d  = {mem_alu_result[31:2], 2'b00};
          hold_wdata_d = mem_write_data;
          cnt_d        = '0;
          if (dmem_ack) begin
            state_d = S_DONE;
            rdata_d = mem_mem_write ? 32'h0 : dmem_rdata;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        cnt_d     = cnt_inc;
        if (dmem_ack) begin
          state_d = S_DONE;
          rdata_d = hold_we_q ? 32'h0 : dmem_rdata;
        end else if (cnt_inc >= CNT_LAST) begin
          // Never acknowledged: finish with zero data and flag it permanently
          state_d   = S_DONE;
          rdata_d   = 32'h0;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        load_rdata = rdata_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MEM/WB next value: clear beats bubble beats load
  always_comb begin
    wb_instr_d      = wb_instr_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_result_src_d = wb_result_src_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_read_data_d  = wb_read_data_q;
    wb_pc_plus_4_d  = wb_pc_plus_4_q;
    wb_imm_ext_d    = wb_imm_ext_q;
    wb_rd_d         = wb_rd_q;
    if (wb_clear) begin
      wb_instr_d      = 32'h0;
      wb_reg_write_d  = 1'b0;
      wb_result_src_d = 2'b00;
      wb_alu_result_d = 32'h0;
      wb_read_data_d  = 32'h0;
      wb_pc_plus_4_d  = 32'h0;
      wb_imm_ext_d    = 32'h0;
      wb_rd_d         = 5'd0;
    end else if (stall_raw) begin
      // Bubble: kill the write-back controls, leave data fields alone
      wb_reg_write_d  = 1'b0;
      wb_result_src_d = 2'b00;
      wb_rd_d         = 5'd0;
    end else begin
      wb_instr_d      = mem_instr;
      wb_reg_write_d  = mem_reg_write;
      wb_result_src_d = mem_result_src;
      wb_alu_result_d = mem_alu_result;
      wb_read_data_d  = load_rdata;
      wb_pc_plus_4_d  = mem_pc_plus_4;
      wb_imm_ext_d    = mem_imm_ext;
      wb_rd_d         = mem_rd;
    end
  end

  // State and pipeline register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      hold_we_q       <= 1'b0;
      hold_addr_q     <= 32'h0;
      hold_wdata_q    <= 32'h0;
      rdata_q         <= 32'h0;
      timeout_q       <= 1'b0;
      wb_instr_q      <= 32'h0;
      wb_reg_write_q  <= 1'b0;
      wb_result_src_q <= 2'b00;
      wb_alu_result_q <= 32'h0;
      wb_read_data_q  <= 32'h0;
      wb_pc_plus_4_q  <= 32'h0;
      wb_imm_ext_q    <= 32'h0;
      wb_rd_q         <= 5'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hold_we_q       <= hold_we_d;
      hold_addr_q     <= hold_addr_d;
      hold_wdata_q    <= hold_wdata_d;
      rdata_q         <= rdata_d;
      timeout_q       <= timeout_d;
      wb_instr_q      <= wb_instr_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_result_src_q <= wb_result_src_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_pc_plus_4_q  <= wb_pc_plus_4_d;
      wb_imm_ext_q    <= wb_imm_ext_d;
      wb_rd_q         <= wb_rd_d;
    end
  end

  // Request and stall drop as soon as reset is seen low, not one edge later
  assign dmem_req      = req_raw & reset;
  assign mem_stall_req = stall_raw & reset;
  assign dmem_timeout  = timeout_q;

  assign wb_instr      = wb_instr_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_result_src = wb_result_src_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_pc_plus_4  = wb_pc_plus_4_q;
  assign wb_imm_ext    = wb_imm_ext_q;
  assign wb_rd         = wb_rd_q;

endmodule
